// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage and the ALU itself: widths, opcode enum
// and the stored issue-entry layout.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 5;
    localparam int RA_W = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e          op;
        logic [RA_W-1:0]  rs1;
        logic [RA_W-1:0]  rs2;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic             use_imm;
        logic             use_pc;
        logic [RA_W-1:0]  rd;
        logic             rd_we;
    } issue_entry_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand from MEM/WB bypass or the stored value, and flags
// a load-use hazard when MEM holds the producer but cannot forward yet.
module operand_bypass_mux
    import alu_pkg::*;
(
    input  logic [RA_W-1:0] idx,
    input  logic            used,
    input  logic [XLEN-1:0] stored,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_we,
    input  logic            mem_fwd_ok,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] value,
    output logic            hazard
);

    logic nonzero;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        nonzero = (idx != '0);
        mem_hit = nonzero & mem_we & (mem_rd == idx);
        wb_hit  = nonzero & wb_we & (wb_rd == idx);

        // x0 is hard zero; MEM is younger than WB so it wins
        value = stored;
        if (!nonzero)
            value = '0;
        else if (mem_hit)
            value = mem_result;
        else if (wb_hit)
            value = wb_result;

        hazard = used & mem_hit & ~mem_fwd_ok;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry decode->ALU register: captures a decoded instruction, resolves its
// operands through MEM/WB bypass each cycle, and stalls on load-use hazards.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [OP_W-1:0] dec_alu_op,
    input  logic [RA_W-1:0] dec_rs1,
    input  logic [RA_W-1:0] dec_rs2,
    input  logic [XLEN-1:0] dec_rs1_data,
    input  logic [XLEN-1:0] dec_rs2_data,
    input  logic [XLEN-1:0] dec_imm,
    input  logic            dec_use_imm,
    input  logic            dec_use_pc,
    input  logic [XLEN-1:0] dec_pc,
    input  logic [RA_W-1:0] dec_rd,
    input  logic            dec_rd_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_we,
    input  logic            mem_fwd_ok,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_result,
    output logic            alu_valid,
    input  logic            alu_ready,
    output logic [OP_W-1:0] alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [RA_W-1:0] alu_rd,
    output logic            alu_rd_we
);

    issue_entry_t    ent_p1;
    issue_entry_t    new_ent;
    logic            full_p1;
    logic            vld_p1;
    logic [XLEN-1:0] byp1;
    logic [XLEN-1:0] byp2;
    logic            hz1;
    logic            hz2;
    logic            hz;
    logic            fire;
    logic            accept;

    operand_bypass_mux u_byp1 (
        .idx        (ent_p1.rs1),
        .used       (~ent_p1.use_pc),
        .stored     (ent_p1.op1),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_fwd_ok (mem_fwd_ok),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_result  (wb_result),
        .value      (byp1),
        .hazard     (hz1)
    );

    operand_bypass_mux u_byp2 (
        .idx        (ent_p1.rs2),
        .used       (~ent_p1.use_imm),
        .stored     (ent_p1.op2),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_fwd_ok (mem_fwd_ok),
        .mem_result (mem_result),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .wb_result  (wb_result),
        .value      (byp2),
        .hazard     (hz2)
    );

    always_comb begin
        hz        = full_p1 & (hz1 | hz2);
        vld_p1    = full_p1 & ~hz & ~flush;
        fire      = vld_p1 & alu_ready;
        dec_ready = ~flush & (~full_p1 | fire);
        accept    = dec_valid & dec_ready;

        new_ent         = '0;
        new_ent.op      = alu_op_e'(dec_alu_op);
        new_ent.rs1     = dec_rs1;
        new_ent.rs2     = dec_rs2;
        new_ent.op1     = dec_rs1_data;
        new_ent.op2     = dec_rs2_data;
        new_ent.imm     = dec_imm;
        new_ent.pc      = dec_pc;
        new_ent.use_imm = dec_use_imm;
        new_ent.use_pc  = dec_use_pc;
        new_ent.rd      = dec_rd;
        new_ent.rd_we   = dec_rd_we;
    end

    // ---- decode -> issue register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            full_p1 <= 1'b0;
            ent_p1  <= '0;
        end else if (flush) begin
            full_p1 <= 1'b0;
        end else if (accept) begin
            full_p1 <= 1'b1;
            ent_p1  <= new_ent;
        end else if (fire) begin
            full_p1 <= 1'b0;
        end else if (full_p1) begin
            // Latch forwarded values so they survive the producer retiring;
            // a source still waiting on a load has nothing valid to latch.
            if (!hz1) ent_p1.op1 <= byp1;
            if (!hz2) ent_p1.op2 <= byp2;
        end
    end

    // ---- issue -> ALU ----
    always_comb begin
        alu_valid = vld_p1;
        alu_op    = ent_p1.op;
        alu_in1   = ent_p1.use_pc  ? ent_p1.pc  : byp1;
        alu_in2   = ent_p1.use_imm ? ent_p1.imm : byp2;
        alu_rd    = ent_p1.rd;
        alu_rd_we = vld_p1 & ent_p1.rd_we;
    end

endmodule
